rv32m_divider: RTL

//  Multi-cycle RV32M divide/remainder unit (DIV, DIVU, REM, REMU) beside the single-cycle ALU in EX.

---
 rtl/rv32m_divider.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/rv32m_divider.sv
`default_nettype none
// ============================================================================
// Module      : rv32m_divider
// Description : Multi-cycle RV32M DIV/DIVU/REM/REMU unit, radix-2 restoring,
//               one quotient bit per cycle, valid/ready handshakes, tag passthrough.
//               Optional build macro DIV_EARLY_TERM_EN: finish at accept when |a| < |b|.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32m_divider #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             kill,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic [TAG_W-1:0] resp_tag
);

    localparam int c_cnt_w = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] c_min = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_div;
    logic               r_q_neg;
    logic               r_r_neg;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_resp_data;
    logic [TAG_W-1:0]   r_resp_tag;

    logic               w_accept;
    logic               w_signed;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic               w_b_zero;
    logic               w_ovf;
    logic               w_early;
    logic               w_special;
    logic [WIDTH-1:0]   w_special_data;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_DONE);
    assign resp_data  = r_resp_data;
    assign resp_tag   = r_resp_tag;

    assign w_accept = req_valid && req_ready && !kill;
    assign w_signed = !req_op[0];
    assign w_abs_a  = (w_signed && req_a[WIDTH-1]) ? -req_a : req_a;
    assign w_abs_b  = (w_signed && req_b[WIDTH-1]) ? -req_b : req_b;
    assign w_b_zero = (req_b == '0);
    assign w_ovf    = w_signed && (req_a == c_min) && (req_b == '1);

`ifdef DIV_EARLY_TERM_EN
    assign w_early = !w_b_zero && (w_abs_a < w_abs_b);
`else
    assign w_early = 1'b0;
`endif

    assign w_special = w_b_zero || w_ovf || w_early;

    // Early-terminated ops share the b==0 remainder rule (r = a); only the quotient differs.
    always_comb begin
        w_special_data = '0;
        if (w_b_zero) begin
            w_special_data = req_op[1] ? req_a : '1;
        end else if (w_ovf) begin
            w_special_data = req_op[1] ? '0 : c_min;
        end else begin
            w_special_data = req_op[1] ? req_a : '0;
        end
    end

    // Partial remainder never exceeds the divisor, so WIDTH+1 bits hold the shifted value.
    assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
    assign w_trial   = w_rem_sh - {1'b0, r_div};
    assign w_quo_fix = (!r_op[0] && r_q_neg) ? -r_quo : r_quo;
    assign w_rem_fix = (!r_op[0] && r_r_neg) ? -r_rem : r_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = w_special ? S_DONE : S_CALC;
            S_CALC: if (r_cnt == '0) w_state_nxt = S_FIX;
            S_FIX:  w_state_nxt = S_DONE;
            S_DONE: if (resp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (kill) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_cnt       <= '0;
            r_resp_data <= '0;
            r_resp_tag  <= '0;
        end else if (!kill) begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op       <= req_op;
                        r_resp_tag <= req_tag;
                        r_rem      <= '0;
                        r_quo      <= w_abs_a;
                        r_div      <= w_abs_b;
                        r_q_neg    <= req_a[WIDTH-1] ^ req_b[WIDTH-1];
                        r_r_neg    <= req_a[WIDTH-1];
                        r_cnt      <= c_cnt_w'(WIDTH - 1);
                        if (w_special) begin
                            r_resp_data <= w_special_data;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
                    r_cnt <= r_cnt - c_cnt_w'(1);
                end
                S_FIX: begin
                    r_resp_data <= r_op[1] ? w_rem_fix : w_quo_fix;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
